// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: funct3 decode, range/alignment checks,
// load extension, and a two-cycle read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_BYTES = 120,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      dm_rdata_i,
  output logic [31:0]      dm_addr_o,
  output logic [31:0]      dm_data_o,
  output logic             dm_write_o,
  output logic             dm_read_o,
  output logic             stall_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             misaligned_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] ld_count_o,
  output logic [CNT_W-1:0] st_count_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]  state;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  logic        any_req;
  logic        f3_ok;
  logic        op_fault;
  logic        range_bad;
  logic        mis;
  logic        ok;
  logic        do_load;
  logic        do_sw;
  logic        do_rmw;
  logic [31:0] merged;
  logic [31:0] load_ext;

  always_comb begin
    any_req = valid_i & (mem_read_i | mem_write_i);
    if (mem_read_i)
      f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    else
      f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    op_fault  = any_req & ((mem_read_i & mem_write_i) | ~f3_ok);
    // 33-bit sum so addresses near 2^32 cannot wrap into the legal window
    range_bad = ({1'b0, addr_i} + 33'd3) >= 33'(MEM_BYTES);
    mis       = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    ok        = any_req & ~op_fault & ~range_bad & ~mis;
    do_load   = ok & mem_read_i;
    do_sw     = ok & mem_write_i & (funct3_i == 3'b010);
    do_rmw    = ok & mem_write_i & (funct3_i[2:1] == 2'b00);
  end

  always_comb begin
    if (funct3_i[0])
      merged = {dm_rdata_i[31:16], wdata_i[15:0]};
    else
      merged = {dm_rdata_i[31:8], wdata_i[7:0]};
    case (funct3_i)
      3'b000:  load_ext = {{24{dm_rdata_i[7]}}, dm_rdata_i[7:0]};
      3'b001:  load_ext = {{16{dm_rdata_i[15]}}, dm_rdata_i[15:0]};
      3'b100:  load_ext = {24'd0, dm_rdata_i[7:0]};
      3'b101:  load_ext = {16'd0, dm_rdata_i[15:0]};
      default: load_ext = dm_rdata_i;
    endcase
  end

  always_comb begin
    dm_addr_o  = 32'd0;
    dm_data_o  = 32'd0;
    dm_write_o = 1'b0;
    dm_read_o  = 1'b0;
    stall_o    = 1'b0;
    if (state == RMW_WR) begin
      dm_write_o = 1'b1;
      dm_addr_o  = rmw_addr;
      dm_data_o  = rmw_data;
    end else if (do_load) begin
      dm_read_o = 1'b1;
      dm_addr_o = addr_i;
    end else if (do_sw) begin
      dm_write_o = 1'b1;
      dm_addr_o  = addr_i;
      dm_data_o  = wdata_i;
    end else if (do_rmw) begin
      dm_read_o = 1'b1;
      dm_addr_o = addr_i;
      stall_o   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rmw_addr      <= 32'd0;
      rmw_data      <= 32'd0;
      rdata_o       <= 32'd0;
      rdata_valid_o <= 1'b0;
      misaligned_o  <= 1'b0;
      fault_o       <= 1'b0;
      ld_count_o    <= '0;
      st_count_o    <= '0;
    end else begin
      rdata_valid_o <= 1'b0;
      misaligned_o  <= 1'b0;
      fault_o       <= 1'b0;
      if (state == RMW_WR) begin
        st_count_o <= st_count_o + CNT_W'(1);
        state      <= IDLE;
      end else begin
        fault_o      <= op_fault | (any_req & ~op_fault & range_bad);
        misaligned_o <= any_req & ~op_fault & ~range_bad & mis;
        if (do_load) begin
          rdata_o       <= load_ext;
          rdata_valid_o <= 1'b1;
          ld_count_o    <= ld_count_o + CNT_W'(1);
        end
        if (do_sw)
          st_count_o <= st_count_o + CNT_W'(1);
        if (do_rmw) begin
          rmw_addr <= addr_i;
          rmw_data <= merged;
          state    <= RMW_WR;
        end
      end
    end
  end

endmodule
